// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, registers the instruction word into a one-entry output stage.
// Optional performance counters are built only when FETCH_PERF_COUNT_EN is defined.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam logic [31:0] LastWord = 32'(MEM_BYTES - 4);

  logic [31:0] pc_q;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic        fault_q;
  logic [1:0]  fault_cause_q;

  logic        load;
  logic [31:0] next_pc;
  logic [31:0] redir_tgt;
  logic        redir_mis;
  logic        redir_oor;

  always_comb begin
    load      = !out_valid_q || out_ready;
    next_pc   = (pc_q >= LastWord) ? 32'h0 : pc_q + 32'd4;
    redir_tgt = {redirect_pc[31:2], 2'b00};
    redir_mis = |redirect_pc[1:0];
    redir_oor = redir_tgt > LastWord;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'h0;
      out_pc_q      <= 32'h0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'b00;
    end else begin
      fault_q <= 1'b0;
      if (redirect_valid) begin
        // Flush wins over any concurrent handshake; no fetch in the redirect cycle.
        out_valid_q <= 1'b0;
        pc_q        <= redir_oor ? 32'h0 : redir_tgt;
        fault_q     <= redir_mis | redir_oor;
        if (redir_mis | redir_oor) begin
          fault_cause_q <= {redir_oor, redir_mis};
        end
      end else if (fetch_en && load) begin
        out_instr_q <= imem_data;
        out_pc_q    <= pc_q;
        out_valid_q <= 1'b1;
        pc_q        <= next_pc;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] perf_fetch_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetch_q <= 32'h0;
      perf_stall_q <= 32'h0;
    end else begin
      if (out_valid_q && out_ready && !redirect_valid) begin
        perf_fetch_q <= perf_fetch_q + 32'd1;
      end
      if (out_valid_q && !out_ready) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

  assign imem_pc     = pc_q;
  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign fault       = fault_q;
  assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a scoreboard of expected {pc, instr} beats.
module tb_instruction_fetch_unit;

`ifdef FETCH_PERF_COUNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic [31:0] imem_pc;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem_bytes [16];
  logic [63:0] sb_q [$];

  always #5 clk = ~clk;

  // Big-endian byte memory; out-of-range addresses return a poison word.
  always_comb begin
    imem_data = 32'hdead_beef;
    if (imem_pc < 32'd16) begin
      imem_data = {mem_bytes[imem_pc[3:0]], mem_bytes[imem_pc[3:0] + 4'd1],
                   mem_bytes[imem_pc[3:0] + 4'd2], mem_bytes[imem_pc[3:0] + 4'd3]};
    end
  end

  instruction_fetch_unit #(
    .RESET_PC  (32'h0),
    .MEM_BYTES (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .imem_pc        (imem_pc),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_cause    (fault_cause),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_at(input int unsigned a);
    return {mem_bytes[a], mem_bytes[a + 1], mem_bytes[a + 2], mem_bytes[a + 3]};
  endfunction

  task automatic sb_push(input logic [31:0] pc);
    sb_q.push_back({pc, word_at(pc)});
  endtask

  task automatic sb_pop(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_pc"}, out_pc, e[63:32]);
      chk({tag, "_instr"}, out_instr, e[31:0]);
    end
  endtask

  task automatic perf_chk(input string tag, input int f, input int s);
    chk({tag, "_fetchcnt"}, perf_fetch_cnt, PerfEn ? 32'(f) : 32'h0);
    chk({tag, "_stallcnt"}, perf_stall_cnt, PerfEn ? 32'(s) : 32'h0);
  endtask

  task automatic redirect(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] words [4];
    words[0] = 32'h8404_1232;
    words[1] = 32'h2543_1789;
    words[2] = 32'h2353_9780;
    words[3] = 32'h2948_1999;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 4; b++) mem_bytes[i * 4 + b] = words[i][31 - 8 * b -: 8];
    end

    reset = 1'b0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", imem_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_outpc", out_pc, 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_cause", 32'(fault_cause), 32'd0);
    perf_chk("rst", 0, 0);

    // Streaming with wrap from the last word back to 0.
    sb_push(0); sb_push(4); sb_push(8); sb_push(12); sb_push(0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      sb_pop($sformatf("stream%0d", i));
    end
    chk("stream_imem_pc", imem_pc, 32'd4);
    perf_chk("stream", 4, 0);

    // Backpressure: output stable, PC frozen.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", out_instr, words[0]);
      chk("stall_outpc", out_pc, 32'h0);
      chk("stall_imem_pc", imem_pc, 32'd4);
    end
    perf_chk("stall", 4, 3);

    out_ready = 1'b1;
    sb_push(4);
    step();
    sb_pop("resume");

    // Redirect with a held beat and ready high: flushed, not counted.
    sb_push(8);
    redirect(32'd8);
    chk("redir8_valid", 32'(out_valid), 32'd0);
    chk("redir8_imem_pc", imem_pc, 32'd8);
    chk("redir8_fault", 32'(fault), 32'd0);
    perf_chk("redir8", 5, 3);
    step();
    sb_pop("redir8_beat");

    sb_push(4);
    redirect(32'd6);
    chk("mis_imem_pc", imem_pc, 32'd4);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_cause", 32'(fault_cause), 32'd1);
    step();
    chk("mis_fault_clear", 32'(fault), 32'd0);
    chk("mis_cause_hold", 32'(fault_cause), 32'd1);
    sb_pop("mis_beat");

    redirect(32'd20);
    chk("oor_imem_pc", imem_pc, 32'd0);
    chk("oor_fault", 32'(fault), 32'd1);
    chk("oor_cause", 32'(fault_cause), 32'd2);
    sb_push(0);
    redirect(32'd21);
    chk("both_imem_pc", imem_pc, 32'd0);
    chk("both_fault", 32'(fault), 32'd1);
    chk("both_cause", 32'(fault_cause), 32'd3);
    step();
    chk("both_fault_clear", 32'(fault), 32'd0);
    sb_pop("both_beat");

    // Last legal word is in range.
    sb_push(12);
    redirect(32'd12);
    chk("last_imem_pc", imem_pc, 32'd12);
    chk("last_fault", 32'(fault), 32'd0);
    step();
    sb_pop("last_beat");
    chk("last_wrap_pc", imem_pc, 32'd0);

    // Reset mid-stream drops the held instruction.
    step();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pc", imem_pc, 32'h0);
    perf_chk("mid_rst", 0, 0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
